// File: rtl/miner_work_loader.sv
`default_nettype none
// ============================================================================
// Module      : miner_work_loader
// Description : Bus-side front end for the SHA-256 miner core.
//               - A 32-bit slave port fills a 768-bit staging buffer
//                 ({data[511:0], midstate[255:0]}), one word at a time.
//               - A commit copies the staging buffer into header_data_input
//                 and raises load_done for one cycle.
//               - The core's golden-nonce result is latched for readback.
// Ports       : clk, reset_n (async, active low)
//               chipselect/write/read/address/writedata -> slave port in
//               readdata          -> registered read data (1-cycle latency)
//               header_data_input -> committed work unit to the miner core
//               load_done         -> 1-cycle strobe, new work is on the header
//               nonce_out         -> from core: [32] found flag, [31:0] nonce
// Revision    : 1.0 - initial release
// ============================================================================
module miner_work_loader #(
    parameter int WORDS  = 24,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_W-1:0]     address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [32*WORDS-1:0]   header_data_input,
    output logic                  load_done,
    input  logic [32:0]           nonce_out
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_PULSE  = 2'd2;
    localparam logic [1:0] c_ST_MINING = 2'd3;

    // Register map: staging words occupy 0..WORDS-1, control follows
    localparam logic [ADDR_W-1:0] c_ADDR_LAST_STAGE = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_COMMIT     = ADDR_W'(WORDS);
    localparam logic [ADDR_W-1:0] c_ADDR_STATUS     = ADDR_W'(WORDS + 1);
    localparam logic [ADDR_W-1:0] c_ADDR_RESULT     = ADDR_W'(WORDS + 2);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [32*WORDS-1:0] r_staging;
    logic [WORDS-1:0]    r_mask;
    logic [31:0]         r_result;
    logic                r_found;
    logic                r_err;
    logic                r_nf_d;

    logic                w_wr;
    logic                w_rd;
    logic                w_commit;
    logic                w_commit_window;
    logic                w_accept_commit;
    logic                w_commit_err;
    logic                w_staged_full;
    logic [WORDS-1:0]    w_stage_sel;
    logic                w_load;
    logic                w_busy;
    logic                w_capture;
    logic                w_rd_result;
    logic [31:0]         w_rdata;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_wr          = chipselect & write;
    assign w_rd          = chipselect & read;
    assign w_commit      = w_wr && (address == c_ADDR_COMMIT) && writedata[0];
    assign w_rd_result   = w_rd && (address == c_ADDR_RESULT);
    assign w_staged_full = &r_mask;

    always_comb begin
        w_stage_sel = '0;
        if (w_wr && (address <= c_ADDR_LAST_STAGE)) begin
            w_stage_sel[address] = 1'b1;
        end
    end

    // Commits are only honoured outside the LOAD/PULSE handshake; one that
    // lands there is dropped silently rather than flagged as an error.
    assign w_accept_commit = w_commit_window & w_commit & w_staged_full;
    assign w_commit_err    = w_commit_window & w_commit & ~w_staged_full;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_MINING: begin
                if (w_accept_commit) begin
                    w_state_next = c_ST_LOAD;
                end
            end
            c_ST_LOAD:  w_state_next = c_ST_PULSE;
            c_ST_PULSE: w_state_next = c_ST_MINING;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_load          = 1'b0;
        load_done       = 1'b0;
        w_busy          = 1'b0;
        w_commit_window = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_commit_window = 1'b1;
            c_ST_LOAD:   w_load          = 1'b1;
            c_ST_PULSE:  load_done       = 1'b1;
            c_ST_MINING: begin
                w_busy          = 1'b1;
                w_commit_window = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Staging buffer and fill mask. The mask clear on LOAD is applied
    // before the new write bit, so a word written during the capture
    // cycle stays marked for the next unit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_staging <= '0;
            r_mask    <= '0;
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (w_stage_sel[i]) begin
                    r_staging[32*i +: 32] <= writedata;
                end
            end
            r_mask <= (w_load ? '0 : r_mask) | w_stage_sel;
        end
    end

    // ------------------------------------------------------------------
    // Committed work unit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            header_data_input <= '0;
        end else if (w_load) begin
            header_data_input <= r_staging;
        end
    end

    // ------------------------------------------------------------------
    // Error flag: sticky until the next successful commit reaches LOAD
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_load) begin
            r_err <= 1'b0;
        end else if (w_commit_err) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result capture. Only a rising edge of the found flag while MINING is
    // taken; a capture beats the read-clear of the same cycle so that the
    // freshly latched nonce is never lost.
    // ------------------------------------------------------------------
    assign w_capture = w_busy & nonce_out[32] & ~r_nf_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nf_d   <= 1'b0;
            r_result <= '0;
            r_found  <= 1'b0;
        end else begin
            r_nf_d <= nonce_out[32];
            if (w_load) begin
                r_found <= 1'b0;
            end else if (w_capture) begin
                r_result <= nonce_out[31:0];
                r_found  <= 1'b1;
            end else if (w_rd_result) begin
                r_found <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: 1-cycle latency, held between reads
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (address == c_ADDR_STATUS) begin
            w_rdata = {28'b0, r_err, w_staged_full, w_busy, r_found};
        end else if (address == c_ADDR_RESULT) begin
            w_rdata = r_result;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (w_rd) begin
            readdata <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miner_work_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_miner_work_loader
// Description : Self-checking bench for miner_work_loader. A word-level
//               model (staging/mask/header arrays plus result flags) tracks
//               what the bus and core have done; each scenario task compares
//               DUT outputs against that model or against fixed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miner_work_loader;

    localparam int WORDS = 24;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         chipselect;
    logic         write;
    logic         read;
    logic [4:0]   address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [767:0] header_data_input;
    logic         load_done;
    logic [32:0]  nonce_out;

    int tests_run    = 0;
    int tests_failed = 0;

    miner_work_loader #(.WORDS(WORDS), .ADDR_W(5)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .chipselect        (chipselect),
        .write             (write),
        .read              (read),
        .address           (address),
        .writedata         (writedata),
        .readdata          (readdata),
        .header_data_input (header_data_input),
        .load_done         (load_done),
        .nonce_out         (nonce_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_stage [WORDS];
    bit          m_mask  [WORDS];
    logic [31:0] m_hdr   [WORDS];
    logic [31:0] m_result;
    bit          m_found, m_err, m_mining, m_flag;
    int          order   [WORDS];

    function automatic void model_reset();
        for (int i = 0; i < WORDS; i++) begin
            m_stage[i] = '0; m_mask[i] = 1'b0; m_hdr[i] = '0;
        end
        m_result = '0; m_found = 0; m_err = 0; m_mining = 0;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < WORDS; i++) if (!m_mask[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        return {28'b0, m_err, m_full(), m_mining, m_found};
    endfunction

    function automatic logic [767:0] m_hdr_packed();
        logic [767:0] v;
        for (int i = 0; i < WORDS; i++) v[32*i +: 32] = m_hdr[i];
        return v;
    endfunction

    function automatic void shuffle_order();
        for (int i = 0; i < WORDS; i++) order[i] = i;
        for (int i = WORDS - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
    endfunction

    // A successful commit: the staged unit becomes the header
    function automatic void model_commit();
        if (m_full()) begin
            for (int i = 0; i < WORDS; i++) begin
                m_hdr[i] = m_stage[i]; m_mask[i] = 1'b0;
            end
            m_found = 0; m_err = 0; m_mining = 1;
        end else begin
            m_err = 1;
        end
    endfunction

    // ---------------- bus / core stimulus ----------------
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
        if (a == 5'd26) m_found = 0;
    endtask

    task automatic stage_word(input int i, input logic [31:0] d);
        bus_write(5'(i), d);
        m_stage[i] = d;
        m_mask[i]  = 1'b1;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    task automatic stage_all_random();
        shuffle_order();
        for (int k = 0; k < WORDS; k++) stage_word(order[k], $urandom);
    endtask

    // Issues a commit (random upper bits) and samples load_done on the
    // four following negedges.
    task automatic do_commit(output logic [3:0] ld);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 5'd24;
        writedata = $urandom | 32'h1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin chipselect = 1'b0; write = 1'b0; end
            ld[k] = load_done;
        end
        model_commit();
    endtask

    task automatic set_nonce(input bit f, input logic [31:0] v);
        @(negedge clk);
        nonce_out = {f, v};
        if (f && !m_flag && m_mining) begin
            m_result = v; m_found = 1;
        end
        m_flag = f;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0; chipselect = 0; write = 0; read = 0;
        address = '0; writedata = '0; nonce_out = '0; m_flag = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (readdata !== 32'h0) begin tests_failed++;
            $display("FAIL reset_readdata: got %h expected 0", readdata); end
        tests_run++;
        if (header_data_input !== 768'h0) begin tests_failed++;
            $display("FAIL reset_header: got %h expected 0", header_data_input); end
        tests_run++;
        if (load_done !== 1'b0) begin tests_failed++;
            $display("FAIL reset_load_done: got %b expected 0", load_done); end
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL reset_status: got %h expected %h", rd, m_status()); end
        // A found edge while IDLE must be ignored
        set_nonce(1'b1, $urandom);
        set_nonce(1'b0, 32'h0);
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL idle_edge_ignored: got %h expected %h", rd, m_status()); end
    endtask

    task automatic test_partial_commit();
        logic [3:0]  ld;
        logic [31:0] rd;
        for (int i = 0; i < WORDS - 1; i++) stage_word(i, $urandom);
        do_commit(ld);
        tests_run++;
        if (ld !== 4'b0000) begin tests_failed++;
            $display("FAIL partial_no_load: got %b expected 0000", ld); end
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status() || rd !== 32'h8) begin tests_failed++;
            $display("FAIL partial_status: got %h expected %h", rd, m_status()); end
        stage_word(WORDS - 1, $urandom);
        do_commit(ld);
        tests_run++;
        if (ld !== 4'b0010) begin tests_failed++;
            $display("FAIL partial_then_full_load: got %b expected 0010", ld); end
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL partial_then_full_status: got %h expected %h", rd, m_status()); end
    endtask

    task automatic test_full_load();
        logic [3:0]  ld;
        logic [31:0] rd;
        shuffle_order();
        for (int k = 0; k < WORDS; k++) stage_word(order[k], 32'h1000_0000 + order[k]);
        do_commit(ld);
        tests_run++;
        if (ld !== 4'b0010) begin tests_failed++;
            $display("FAIL full_load_strobe: got %b expected 0010", ld); end
        tests_run++;
        if (header_data_input[31:0] !== 32'h1000_0000 ||
            header_data_input[767:736] !== 32'h1000_0017) begin tests_failed++;
            $display("FAIL full_load_ends: got %h/%h expected 10000000/10000017",
                     header_data_input[31:0], header_data_input[767:736]); end
        tests_run++;
        if (header_data_input !== m_hdr_packed()) begin tests_failed++;
            $display("FAIL full_load_header: got %h expected %h",
                     header_data_input, m_hdr_packed()); end
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL full_load_status: got %h expected %h", rd, m_status()); end
    endtask

    task automatic test_result_capture();
        logic [31:0] rd, exp;
        set_nonce(1'b1, 32'hDEAD_BEEF);
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL capture_status: got %h expected %h", rd, m_status()); end
        exp = m_result;
        bus_read(5'd26, rd);
        tests_run++;
        if (rd !== exp) begin tests_failed++;
            $display("FAIL capture_result: got %h expected %h", rd, exp); end
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL capture_read_clears: got %h expected %h", rd, m_status()); end
    endtask

    task automatic test_restage_while_mining();
        logic [3:0]  ld;
        logic [31:0] rd, exp;
        stage_all_random();
        tests_run++;
        if (header_data_input !== m_hdr_packed()) begin tests_failed++;
            $display("FAIL restage_header_held: got %h expected %h",
                     header_data_input, m_hdr_packed()); end
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL restage_status_full: got %h expected %h", rd, m_status()); end
        do_commit(ld);
        tests_run++;
        if (ld !== 4'b0010 || header_data_input !== m_hdr_packed()) begin tests_failed++;
            $display("FAIL restage_commit: ld %b hdr %h expected 0010 hdr %h",
                     ld, header_data_input, m_hdr_packed()); end
        // Found flag still high from before: no new edge, nothing captured
        set_nonce(1'b1, $urandom);
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL restage_found_cleared: got %h expected %h", rd, m_status()); end
        set_nonce(1'b0, 32'h0);
        set_nonce(1'b1, $urandom);
        exp = m_result;
        bus_read(5'd26, rd);
        tests_run++;
        if (rd !== exp) begin tests_failed++;
            $display("FAIL restage_recapture: got %h expected %h", rd, exp); end
    endtask

    task automatic test_capture_read_collision();
        logic [31:0] rd, exp;
        set_nonce(1'b0, 32'h0);
        set_nonce(1'b1, 32'h1);
        set_nonce(1'b0, 32'h1);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 5'd26;
        nonce_out = {1'b1, 32'h2};
        exp = m_result;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        m_result = 32'h2; m_found = 1; m_flag = 1;
        tests_run++;
        if (readdata !== exp) begin tests_failed++;
            $display("FAIL collision_old_result: got %h expected %h", readdata, exp); end
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL collision_found_kept: got %h expected %h", rd, m_status()); end
        exp = m_result;
        bus_read(5'd26, rd);
        tests_run++;
        if (rd !== exp) begin tests_failed++;
            $display("FAIL collision_new_result: got %h expected %h", rd, exp); end
    endtask

    task automatic test_stage_during_load();
        logic [31:0] rd, x;
        logic        ld1, ld2;
        stage_all_random();
        x = $urandom;
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 5'd24; writedata = 32'h1;
        @(negedge clk);
        address = 5'd5; writedata = x;          // lands in the LOAD cycle
        ld1 = load_done;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        ld2 = load_done;
        model_commit();
        m_stage[5] = x; m_mask[5] = 1'b1;
        tests_run++;
        if (ld1 !== 1'b0 || ld2 !== 1'b1) begin tests_failed++;
            $display("FAIL load_write_strobe: got %b%b expected 01", ld1, ld2); end
        tests_run++;
        if (header_data_input !== m_hdr_packed()) begin tests_failed++;
            $display("FAIL load_write_excluded: got %h expected %h",
                     header_data_input, m_hdr_packed()); end
        // Bit 5 is the only mask bit set, so a partial commit must error
        bus_write(5'd24, 32'h1);
        model_commit();
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL load_write_mask_kept: got %h expected %h", rd, m_status()); end
    endtask

    task automatic test_random();
        logic [3:0]  ld, exp_ld;
        logic [31:0] rd, exp;
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                stage_all_random();
            end else begin
                int n;
                n = $urandom_range(0, 10);
                for (int k = 0; k < n; k++) stage_word($urandom_range(0, WORDS - 1), $urandom);
            end
            exp_ld = m_full() ? 4'b0010 : 4'b0000;
            do_commit(ld);
            tests_run++;
            if (ld !== exp_ld || header_data_input !== m_hdr_packed()) begin tests_failed++;
                $display("FAIL random_commit_%0d: ld %b hdr %h expected %b hdr %h",
                         it, ld, header_data_input, exp_ld, m_hdr_packed()); end
            set_nonce(1'b0, 32'h0);
            set_nonce(1'b1, $urandom);
            bus_read(5'd25, rd);
            tests_run++;
            if (rd !== m_status()) begin tests_failed++;
                $display("FAIL random_status_%0d: got %h expected %h", it, rd, m_status()); end
            exp = m_result;
            bus_read(5'd26, rd);
            tests_run++;
            if (rd !== exp) begin tests_failed++;
                $display("FAIL random_result_%0d: got %h expected %h", it, rd, exp); end
        end
    endtask

    task automatic test_read_map();
        logic [31:0] rd, held;
        bus_read(5'($urandom_range(0, WORDS - 1)), rd);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++;
            $display("FAIL map_stage_read: got %h expected 0", rd); end
        bus_read(5'($urandom_range(27, 31)), rd);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++;
            $display("FAIL map_unused_read: got %h expected 0", rd); end
        // Non-commit writes: addr 24 with bit0 clear, unused address
        bus_write(5'd24, $urandom & 32'hFFFF_FFFE);
        bus_write(5'($urandom_range(27, 31)), $urandom);
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL map_ignored_writes: got %h expected %h", rd, m_status()); end
        held = m_result;
        bus_read(5'd26, rd);
        repeat (4) @(negedge clk);
        tests_run++;
        if (readdata !== held) begin tests_failed++;
            $display("FAIL map_readdata_held: got %h expected %h", readdata, held); end
    endtask

    task automatic test_reset_in_pulse();
        logic [31:0] rd;
        logic        ld_seen;
        set_nonce(1'b0, 32'h0);
        stage_all_random();
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 5'd24; writedata = 32'h1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        @(negedge clk);
        tests_run++;
        if (load_done !== 1'b1) begin tests_failed++;
            $display("FAIL pulse_before_reset: got %b expected 1", load_done); end
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if (load_done !== 1'b0 || header_data_input !== 768'h0) begin tests_failed++;
            $display("FAIL reset_in_pulse: ld %b hdr %h expected 0 and 0",
                     load_done, header_data_input); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        ld_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            ld_seen = ld_seen | load_done;
        end
        tests_run++;
        if (ld_seen !== 1'b0) begin tests_failed++;
            $display("FAIL no_load_after_reset: got %b expected 0", ld_seen); end
        bus_read(5'd25, rd);
        tests_run++;
        if (rd !== m_status()) begin tests_failed++;
            $display("FAIL status_after_reset: got %h expected %h", rd, m_status()); end
    endtask

    initial begin
        test_reset();
        test_partial_commit();
        test_full_load();
        test_result_capture();
        test_restage_while_mining();
        test_capture_read_collision();
        test_stage_during_load();
        test_random();
        test_read_map();
        test_reset_in_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
